// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter that lets one of four requesters drive a shared 8-bit bidirectional pin bus.
// Define UIO_BUS_TURNAROUND_EN to insert one idle bus cycle between consecutive owners.
module uio_bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [31:0] req_oe,
    output logic [3:0]  gnt,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic        busy
);

`ifdef UIO_BUS_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  hold_q, hold_d;

    logic [3:0]  ereq;
    logic [3:0]  cand;
    logic [1:0]  idx;
    logic [1:0]  win;
    logic        win_valid;
    logic        owner_end;

    // Candidates exclude the current owner, so the same search serves idle arbitration and handover.
    always_comb begin
        ereq      = ena ? req : 4'b0000;
        cand      = ereq & ~gnt_q;
        idx       = 2'd0;
        win       = 2'd0;
        win_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!win_valid && cand[idx]) begin
                win_valid = 1'b1;
                win       = idx;
            end
        end
        owner_end = ((ereq & gnt_q) == 4'b0000) ||
                    ((hold_q == HOLD_LAST) && (cand != 4'b0000));
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            GRANT: begin
                if (owner_end) begin
`ifdef UIO_BUS_TURNAROUND_EN
                    state_d = TURN;
                    gnt_d   = 4'b0000;
                    hold_d  = 8'd0;
`else
                    if (win_valid) begin
                        gnt_d  = 4'b0001 << win;
                        last_d = win;
                        hold_d = 8'd0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        hold_d  = 8'd0;
                    end
`endif
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                // IDLE and TURN arbitrate identically.
                gnt_d = 4'b0000;
                if (win_valid) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    last_d  = win;
                    hold_d  = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            last_q  <= 2'd3;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Pin mux follows the registered grant so the bus never sees a glitching owner.
    always_comb begin
        uio_out = 8'h00;
        uio_oe  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (gnt_q[i]) begin
                uio_out = req_data[8*i +: 8];
                uio_oe  = req_oe[8*i +: 8];
            end
        end
    end

    assign gnt  = gnt_q;
    assign busy = (gnt_q != 4'b0000);

endmodule

// File: doc/uio_bus_arbiter.md
UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive grant cycles while another requester waits (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: ena  input  1  design enable; low masks all requests.
REQ-005 Port: req  input  4  request per requester i (bit i).
REQ-006 Port: req_data  input  32  requester i drive value in bits [8i+7:8i].
REQ-007 Port: req_oe  input  32  requester i output-enable in bits [8i+7:8i].
REQ-008 Port: gnt  output  4  registered one-hot grant, all-zero when bus free.
REQ-009 Port: uio_out  output  8  shared bidirectional pin drive value.
REQ-010 Port: uio_oe  output  8  shared pin output enable, 1 = drive.
REQ-011 Port: busy  output  1  high whenever gnt is non-zero.

Function
REQ-012 States: IDLE (gnt=0), GRANT (exactly one gnt bit set), TURN (gnt=0; present only with macro, REQ-024).
REQ-013 Effective request: ereq = req when ena=1, else 4'b0000.
REQ-014 IDLE: on edge with any ereq bit set, go to GRANT; gnt takes the round-robin winner the same edge; request-to-grant latency is 1 cycle.
REQ-015 Round-robin: search starts at index (last_gnt+1) mod 4 and wraps; last_gnt updates on every new grant.
REQ-016 uio_out = req_data slice and uio_oe = req_oe slice of the granted index, combinational from registered gnt; both 8'h00 when gnt=0.
REQ-017 Hold counter: cleared on every new grant, incremented each GRANT cycle, saturating at MAX_HOLD-1.
REQ-018 Release: in GRANT, owner releases on an edge where ereq[owner]=0.
REQ-019 Preemption: in GRANT, owner is revoked on an edge where hold counter = MAX_HOLD-1 and any other ereq bit is set.
REQ-020 Sole requester is never preempted; it keeps the grant indefinitely with the counter saturated.
REQ-021 On release or preemption without macro: if another ereq bit is set, the next round-robin winner is granted on that same edge (counter cleared); otherwise go to IDLE.
REQ-022 ena falling during GRANT: the grant drops on the next edge (via REQ-013/REQ-018); gnt never asserts while ena=0.
REQ-023 gnt is never multi-hot; a newly requesting index never displaces the owner before REQ-018/REQ-019.

Configuration
REQ-024 Macro UIO_BUS_TURNAROUND_EN defined: every ownership end (release or preemption) passes through TURN for exactly one cycle (gnt=0, uio_oe=8'h00), then TURN arbitrates as IDLE does.
REQ-025 Macro undefined: TURN state absent; owner-to-owner handover is back-to-back with zero idle cycles.

Reset
REQ-026 rst_n low asynchronously forces IDLE, gnt=4'b0000, busy=0, uio_out=8'h00, uio_oe=8'h00, hold counter=0.
REQ-027 Reset sets last_gnt=3, so requester 0 has top priority after reset.
REQ-028 Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge; the first grant after rst_n rises follows REQ-014.

Verification
REQ-029 Reset, then req=4'b1010 held -> gnt=4'b0010 one cycle later; uio_out/uio_oe equal slice 1.
REQ-030 req=4'b1111 held, MAX_HOLD=4, no macro -> gnt sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles, no gap.
REQ-031 Same stimulus with UIO_BUS_TURNAROUND_EN -> same order, one cycle of gnt=0/uio_oe=8'h00 between each owner.
REQ-032 Only req[2] high for 100 cycles -> gnt=4'b0100 throughout; no preemption.
REQ-033 Owner 0 granted, ena driven low -> gnt=0 on next edge; gnt stays 0 while ena=0 despite req=4'b1111.
REQ-034 rst_n pulsed low mid-grant between edges -> gnt, uio_oe read 0 before the next edge; after release, req=4'b1000 -> gnt=4'b1000 one cycle later.
